// File: rtl/corevx_ptw.sv
// corevx_ptw: Sv32 hardware page-table walker for the corevx cache.
//
// On a TLB miss the cache hands over a 20-bit VPN. The walker reads one or
// two 32-bit PTEs over an Avalon-MM read port and returns the PPN plus the raw
// 8-bit accesstag (D A G U X W R V). Permission checks are done elsewhere.
// The walker reports only structural PTE faults and bus errors.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   resolve_request           walk request, level-sensitive, sampled in IDLE
//   resolve_virtual_address   VPN[19:0] to translate
//   resolve_ack               1-cycle pulse: request accepted, VPN latched
//   resolve_done              1-cycle pulse: result outputs valid this cycle
//   resolve_pagefault         structural PTE fault (with done)
//   resolve_accessfault       bus error during the walk (with done)
//   resolve_physical_address  PPN[21:0] (with done, no fault)
//   resolve_accesstag         PTE[7:0] (with done, no fault)
//   satp_ppn                  root page-table PPN, used only at accept
//   avl_address, avl_read     PTE read request (byte address)
//   avl_waitrequest           read stall
//   avl_readdatavalid,
//   avl_readdata,
//   avl_response              read return; response 00 = OKAY
//
// Handshake: a read is accepted on a rising edge where avl_read=1 and
// avl_waitrequest=0; avl_read and avl_address hold steady until then. Read
// data is taken on the first edge with avl_readdatavalid=1 while in WAIT.
//
// Timing: the ack cycle presents the root PTE address with avl_read still low;
// avl_read rises the following cycle. The second-level read is raised on the
// same edge that evaluates the first-level PTE, since its address is known.

module corevx_ptw #(
  parameter int VERBOSE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_accesstag,
  input  logic [21:0] satp_ppn,
  output logic [33:0] avl_address,
  output logic        avl_read,
  input  logic        avl_waitrequest,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic [1:0]  avl_response
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        level;   // 1 = root table, 0 = leaf table
  logic [19:0] vpn;

  // PTE field decode
  logic pte_v, pte_r, pte_w, pte_x, pte_leaf;
  assign pte_v    = avl_readdata[0];
  assign pte_r    = avl_readdata[1];
  assign pte_w    = avl_readdata[2];
  assign pte_x    = avl_readdata[3];
  assign pte_leaf = pte_r | pte_x;

  // The VERBOSE parameter and the software-reserved RSW bits never affect the walk.
  logic lint_unused;
  assign lint_unused = (VERBOSE != 0) ^ (^avl_readdata[9:8]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      level                    <= 1'b1;
      vpn                      <= '0;
      resolve_ack              <= 1'b0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_accesstag        <= '0;
      avl_address              <= '0;
      avl_read                 <= 1'b0;
    end else begin
      resolve_ack  <= 1'b0;
      resolve_done <= 1'b0;
      case (state)
        IDLE: begin
          if (resolve_request) begin
            resolve_ack <= 1'b1;
            vpn         <= resolve_virtual_address;
            level       <= 1'b1;
            avl_address <= {satp_ppn, resolve_virtual_address[19:10], 2'b00};
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!avl_read) begin
            avl_read <= 1'b1;
          end else if (!avl_waitrequest) begin
            avl_read <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (avl_readdatavalid) begin
            // Default outcome is a completed walk; only the pointer case
            // at the root level overrides this and loops back to ISSUE.
            state        <= DONE;
            resolve_done <= 1'b1;
            if (avl_response != 2'b00) begin
              resolve_accessfault <= 1'b1;
            end else if (!pte_v || (!pte_r && pte_w)) begin
              resolve_pagefault <= 1'b1;
            end else if (pte_leaf) begin
              if (level && (avl_readdata[19:10] != 10'd0)) begin
                // superpage whose PPN0 is not zero is misaligned
                resolve_pagefault <= 1'b1;
              end else if (level) begin
                resolve_physical_address <= {avl_readdata[31:20], vpn[9:0]};
                resolve_accesstag        <= avl_readdata[7:0];
              end else begin
                resolve_physical_address <= avl_readdata[31:10];
                resolve_accesstag        <= avl_readdata[7:0];
              end
            end else if (level) begin
              level        <= 1'b0;
              avl_address  <= {avl_readdata[31:10], vpn[9:0], 2'b00};
              avl_read     <= 1'b1;
              state        <= ISSUE;
              resolve_done <= 1'b0;
            end else begin
              resolve_pagefault <= 1'b1;
            end
          end
        end
        DONE: begin
          // results are only valid alongside the done pulse
          resolve_pagefault        <= 1'b0;
          resolve_accessfault      <= 1'b0;
          resolve_physical_address <= '0;
          resolve_accesstag        <= '0;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
